serial_add_ctrl: RTL and testbench
==================================

# serial_add_ctrl

Bit-serial adder controller. Accepts two WIDTH-bit operands and a carry-in, then time-multiplexes one gate-level full-adder cell over WIDTH cycles, LSB first. It registers the running carry and the partial sum, and returns a WIDTH-bit sum plus carry-out with a start/busy/done handshake. It lets wide additions run on a single full-adder datapath where area matters more than latency.

## Interface
Parameters:
- WIDTH, default 8: operand and sum width in bits; legal range WIDTH ≥ 1.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  request. Sampled only in IDLE; ignored in every other state.
- a  in  WIDTH  operand A, sampled on the accepting edge.
- b  in  WIDTH  operand B, sampled on the accepting edge.
- cin  in  1  carry-in, sampled on the accepting edge.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse; high while in DONE.
- sum  out  WIDTH  result. Valid from the DONE cycle until the next accepted start.
- cout  out  1  carry-out. Valid with sum.

## Operation
- States:
  - IDLE: waiting for a request.
  - RUN: computing one bit per cycle.
  - DONE: result presented for one cycle.
- Transitions:
  - IDLE→RUN when start=1.
  - RUN→DONE after WIDTH RUN cycles, i.e. when cnt == WIDTH-1 at the edge.
  - DONE→IDLE unconditionally.
- Accept edge (IDLE, start=1) loads:
  - a_sh ← a, b_sh ← b, carry ← cin, cnt ← 0.
  - sum_sh ← 0, cout ← 0.
- Each RUN edge:
  - Full-adder cell inputs are (a_sh[0], b_sh[0], carry), giving outputs (s, c).
  - a_sh and b_sh shift right by 1, with 0 shifted into the MSB.
  - sum_sh ← {s, sum_sh[WIDTH-1:1]}, so the bit enters at the MSB and shifts toward the LSB.
  - carry ← c; cnt ← cnt+1.
  - On the last RUN edge, cout ← c as well.
- sum is driven from sum_sh. After WIDTH shifts, bit i of sum equals bit i of (a+b+cin).
- Arithmetic is modulo 2^WIDTH. cout is bit WIDTH of a+b+cin. No overflow or sign handling.
- The cnt register is $clog2(WIDTH+1) bits wide. WIDTH=1: a single RUN cycle.
- start held high continuously: one addition per WIDTH+2 cycles (IDLE, WIDTH×RUN, DONE).
- start, a, b or cin changing during RUN or DONE: no effect.
- Reset in any state, including mid-RUN:
  - Next state is IDLE.
  - busy=0, done=0, sum=0, cout=0, cnt=0, carry=0, shift registers 0.
  - The partial result is discarded.
  - Reset has priority over start on the same edge.

## Timing
- Accept edge E0; RUN edges E1..E_WIDTH.
- done=1 and busy=0 in the cycle after E_WIDTH.
- sum and cout are valid in that same cycle.
- Latency from start sampled to done high: WIDTH+1 cycles.
- busy is high for exactly WIDTH cycles, starting the cycle after E0.
- done is never high on consecutive cycles. done and busy are never both high.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- Package serial_add_pkg:
  - typedef enum logic [1:0] state_t with values {IDLE, RUN, DONE}.
  - Reset-value constants.
- Sub-module full_adder_cell (ports a, b, cin, sum, carry):
  - Purely combinational.
  - Built from and/or/xor gate primitives on internal nets.
  - Instantiated exactly once.
- Top level holds:
  - the FSM;
  - the counter;
  - the operand and sum shift registers;
  - the carry flop.

## Test plan
All scenarios use WIDTH=8.
- Reset, then idle 5 cycles → busy=0, done=0, sum=0x00, cout=0 throughout.
- a=0x5A, b=0x3C, cin=0, start pulse → busy high 8 cycles; done in cycle 9 after accept; sum=0x96, cout=0.
- a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 → sum=0xFF, cout=1.
- start=1 held, with operands changed every cycle during RUN → only the accept-edge operands are used; next accept occurs exactly 10 cycles after the first.
- rst=1 on the 4th RUN cycle → IDLE next cycle with all outputs 0. A fresh start with a=0x01, b=0x02, cin=0 then yields sum=0x03, cout=0.
- Random sweep of 1000 (a, b, cin) triples, plus WIDTH=1 instance exhaustive over 8 input combinations → sum/cout match a+b+cin; done latency always WIDTH+1.

Source files
------------

// File: rtl/serial_add_pkg.sv
// Package for the bit-serial adder controller.
// Holds the FSM state encoding and the reset values of the scalar control
// state. Width-dependent registers reset to all-zeros in the top level.
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam state_t STATE_RST = IDLE;
  localparam logic   CARRY_RST = 1'b0;
  localparam logic   COUT_RST  = 1'b0;
  localparam logic   BUSY_RST  = 1'b0;
  localparam logic   DONE_RST  = 1'b0;

endpackage

// File: rtl/full_adder_cell.sv
// Single-bit full adder built from gate primitives.
// Purely combinational; the serial adder reuses this one cell every cycle.
// Ports:
//   a, b, cin : addend bits and carry-in
//   sum       : a ^ b ^ cin
//   carry     : majority(a, b, cin)
module full_adder_cell (
  input  wire a,
  input  wire b,
  input  wire cin,
  output wire sum,
  output wire carry
);

  wire axb_s;
  wire ab_s;
  wire cx_s;

  xor g_axb  (axb_s, a, b);
  xor g_sum  (sum, axb_s, cin);
  and g_ab   (ab_s, a, b);
  and g_cx   (cx_s, axb_s, cin);
  or  g_cout (carry, ab_s, cx_s);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller.
// Adds two WIDTH-bit operands plus a carry-in one bit per cycle, LSB first,
// through a single full-adder cell. Sum bits enter the sum shift register at
// the MSB so that after WIDTH shifts bit i sits at position i.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   start         : request, sampled only in IDLE
//   a, b, cin     : operands and carry-in, captured on the accepting edge
//   busy          : high during the WIDTH RUN cycles
//   done          : one-cycle pulse when the result is presented
//   sum, cout     : result, valid from done until the next accepted start
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int             CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  wire fa_s;
  wire fa_c;

  full_adder_cell u_fa (
    .a     (a_sh_q[0]),
    .b     (b_sh_q[0]),
    .cin   (carry_q),
    .sum   (fa_s),
    .carry (fa_c)
  );

  // Next-state, datapath and output-flag logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    carry_d  = carry_q;
    cout_d   = cout_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = RUN;
          a_sh_d   = a;
          b_sh_d   = b;
          carry_d  = cin;
          cnt_d    = '0;
          sum_sh_d = '0;
          cout_d   = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        // shift right, new sum bit lands in the MSB (works for WIDTH=1 too)
        sum_sh_d = sum_sh_q >> 1;
        sum_sh_d[WIDTH-1] = fa_s;
        carry_d  = fa_c;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          cout_d  = fa_c;
        end else begin
          state_d = RUN;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // flags are decoded from the next state so they come straight off flops
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  // State, datapath and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= STATE_RST;
      cnt_q    <= '0;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      carry_q  <= CARRY_RST;
      cout_q   <= COUT_RST;
      busy_q   <= BUSY_RST;
      done_q   <= DONE_RST;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_sh_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl: a WIDTH=8 instance and a WIDTH=1
// instance. Stimulus pushes expected results; monitors pop on done.
module tb_serial_add_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic       start8 = 1'b0, cin8 = 1'b0;
  logic [7:0] a8 = 8'h00, b8 = 8'h00;
  logic       busy8, done8, cout8;
  logic [7:0] sum8;

  logic       start1 = 1'b0, cin1 = 1'b0;
  logic [0:0] a1 = 1'b0, b1 = 1'b0;
  logic       busy1, done1, cout1;
  logic [0:0] sum1;

  serial_add_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_add_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  typedef struct {
    logic [7:0] sum;
    logic       cout;
    int         t0;
  } exp_t;

  exp_t sb8[$];
  exp_t sb1[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor for the WIDTH=8 instance
  initial begin
    int   bc = 0;
    logic pd = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        bc = 0;
      end else begin
        if (busy8) bc++;
        if (done8) begin
          if (sb8.size() == 0) begin
            check("done8_unexpected", 1, 0);
          end else begin
            e = sb8.pop_front();
            check("sum8", int'(sum8), int'(e.sum));
            check("cout8", int'(cout8), int'(e.cout));
            check("latency8", cyc - e.t0, 9);
            check("busy_run8", bc, 8);
            check("busy_and_done8", int'(busy8), 0);
            check("done_repeat8", int'(pd), 0);
          end
          bc = 0;
        end
      end
      pd = done8;
    end
  end

  // Monitor for the WIDTH=1 instance
  initial begin
    int   bc = 0;
    logic pd = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        bc = 0;
      end else begin
        if (busy1) bc++;
        if (done1) begin
          if (sb1.size() == 0) begin
            check("done1_unexpected", 1, 0);
          end else begin
            e = sb1.pop_front();
            check("sum1", int'(sum1), int'(e.sum[0]));
            check("cout1", int'(cout1), int'(e.cout));
            check("latency1", cyc - e.t0, 2);
            check("busy_run1", bc, 1);
            check("busy_and_done1", int'(busy1), 0);
            check("done_repeat1", int'(pd), 0);
          end
          bc = 0;
        end
      end
      pd = done1;
    end
  end

  task automatic wait_done8();
    bit seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done8) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check("done8_timeout", 0, 1);
  endtask

  task automatic wait_done1();
    bit seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done1) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check("done1_timeout", 0, 1);
  endtask

  // Issue one addition on the 8-bit instance; operands are scrambled during RUN
  task automatic run_add8(input logic [7:0] a, input logic [7:0] b, input logic ci,
                          input logic [7:0] es, input logic ec);
    @(negedge clk);
    a8 = a; b8 = b; cin8 = ci; start8 = 1'b1;
    sb8.push_back('{es, ec, cyc});
    @(negedge clk);
    start8 = 1'b0;
    a8 = ~a; b8 = 8'($urandom); cin8 = ~ci;
    wait_done8();
  endtask

  task automatic run_add1(input logic a, input logic b, input logic ci,
                          input logic es, input logic ec);
    @(negedge clk);
    a1 = a; b1 = b; cin1 = ci; start1 = 1'b1;
    sb1.push_back('{{7'd0, es}, ec, cyc});
    @(negedge clk);
    start1 = 1'b0;
    a1 = ~a; b1 = ~b; cin1 = ~ci;
    wait_done1();
  endtask

  initial begin
    logic [7:0] ra, rb;
    logic       rc;
    logic [8:0] rs;
    logic [1:0] t;

    // reset, then idle
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle_busy", int'(busy8), 0);
      check("idle_done", int'(done8), 0);
      check("idle_sum", int'(sum8), 0);
      check("idle_cout", int'(cout8), 0);
    end
    check("idle_busy1", int'(busy1), 0);
    check("idle_sum1", int'(sum1), 0);

    // directed vectors
    run_add8(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0);
    run_add8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    run_add8(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
    run_add8(8'h00, 8'h00, 1'b1, 8'h01, 1'b0);
    run_add8(8'h80, 8'h7F, 1'b1, 8'h00, 1'b1);

    // start held high, operands churning: second accept exactly 10 cycles later
    @(negedge clk);
    a8 = 8'h12; b8 = 8'h34; cin8 = 1'b1; start8 = 1'b1;
    sb8.push_back('{8'h47, 1'b0, cyc});
    repeat (9) begin
      @(negedge clk);
      a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
    end
    @(negedge clk);
    a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0;
    sb8.push_back('{8'h00, 1'b1, cyc});
    @(negedge clk);
    start8 = 1'b0;
    a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b1;
    wait_done8();

    // reset during the 4th RUN cycle discards the partial result
    @(negedge clk);
    a8 = 8'h77; b8 = 8'h11; cin8 = 1'b1; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    check("busy_before_rst", int'(busy8), 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_busy", int'(busy8), 0);
    check("rst_done", int'(done8), 0);
    check("rst_sum", int'(sum8), 0);
    check("rst_cout", int'(cout8), 0);
    @(negedge clk);
    rst = 1'b0;
    run_add8(8'h01, 8'h02, 1'b0, 8'h03, 1'b0);

    // random sweep against a+b+cin
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      rs = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
      run_add8(ra, rb, rc, rs[7:0], rs[8]);
    end

    // WIDTH=1 exhaustive
    for (int i = 0; i < 8; i++) begin
      t = 2'(i[2]) + 2'(i[1]) + 2'(i[0]);
      run_add1(i[2], i[1], i[0], t[0], t[1]);
    end

    repeat (3) @(negedge clk);
    check("sb8_drained", sb8.size(), 0);
    check("sb1_drained", sb1.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
